uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 26 ++
 rtl/uart_rx_frame_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state encoding, error codes and framing defaults for the UART frame controller.
// Pure declarations: no logic, no latency, no backpressure.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DELIVER = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_BREAK   = 3'd4;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register file, one synchronous write port, combinational read.
// Write lands on the next clk edge; read reflects the addressed entry immediately; no backpressure.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Storage carries no reset: a frame is only read back after every slot it uses was written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Collects SYNC/LEN/payload/CSUM frames from a UART receiver and replays verified payload on valid/ready.
// frm_valid rises one cycle after a good CSUM byte; holds while frm_ready is low; bytes arriving in DELIVER are dropped and counted.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 104_160
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    output logic       rx_en,
    input  logic       rx_valid,
    input  logic       rx_break,
    input  logic [7:0] rx_data,
    output logic [7:0] frm_data,
    output logic       frm_valid,
    input  logic       frm_ready,
    output logic       frm_last,
    output logic       frm_done,
    output logic       frm_err,
    output logic [2:0] err_code,
    output logic [7:0] overrun_cnt
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_len_nxt;
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] w_wr_ptr_nxt;
    logic [LW-1:0] r_rd_ptr;
    logic [LW-1:0] w_rd_ptr_nxt;
    logic [7:0]    r_csum;
    logic [7:0]    w_csum_nxt;
    logic [TW-1:0] r_to_cnt;
    logic          r_rx_en;
    logic          r_frm_done;
    logic          r_frm_err;
    logic [2:0]    r_err_code;
    logic [7:0]    r_overrun;

    logic          w_err;
    logic [2:0]    w_err_code;
    logic          w_done;
    logic          w_buf_we;
    logic          w_ovr_inc;
    logic          w_to_run;
    logic          w_to_expired;
    logic          w_xfer;
    logic          w_last;
    logic [7:0]    w_rd_dat;

    assign rx_en        = r_rx_en;
    assign frm_valid    = (r_state == ST_DELIVER);
    assign w_last       = (r_rd_ptr == r_len - LW'(1));
    assign w_xfer       = frm_valid && frm_ready;
    assign w_to_expired = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign frm_data     = frm_valid ? w_rd_dat : 8'h00;
    assign frm_last     = frm_valid && w_last;
    assign frm_done     = r_frm_done;
    assign frm_err      = r_frm_err;
    assign err_code     = r_err_code;
    assign overrun_cnt  = r_overrun;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (rx_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_dat)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_csum_nxt   = r_csum;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        w_done       = 1'b0;
        w_buf_we     = 1'b0;
        w_ovr_inc    = 1'b0;
        w_to_run     = 1'b0;

        // Disabling is a silent abort: no error, no done, straight back to IDLE.
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_valid && !rx_break && (rx_data == SYNC_BYTE)) begin
                        w_state_nxt = ST_LEN;
                    end
                end

                ST_LEN: begin
                    w_to_run = 1'b1;
                    if (rx_valid) begin
                        if (rx_break) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_BREAK;
                        end else if ((rx_data == 8'd0) || (int'(rx_data) > MAX_LEN)) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_LEN;
                        end else begin
                            w_state_nxt  = ST_PAYLOAD;
                            w_len_nxt    = rx_data[LW-1:0];
                            w_csum_nxt   = rx_data;
                            w_wr_ptr_nxt = '0;
                        end
                    end else if (w_to_expired) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_TIMEOUT;
                    end
                end

                ST_PAYLOAD: begin
                    w_to_run = 1'b1;
                    if (rx_valid) begin
                        if (rx_break) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_BREAK;
                        end else begin
                            w_buf_we     = 1'b1;
                            w_csum_nxt   = r_csum ^ rx_data;
                            w_wr_ptr_nxt = r_wr_ptr + LW'(1);
                            if (r_wr_ptr == r_len - LW'(1)) begin
                                w_state_nxt = ST_CSUM;
                            end
                        end
                    end else if (w_to_expired) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_TIMEOUT;
                    end
                end

                ST_CSUM: begin
                    w_to_run = 1'b1;
                    if (rx_valid) begin
                        if (rx_break) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_BREAK;
                        end else if (rx_data == r_csum) begin
                            w_state_nxt  = ST_DELIVER;
                            w_rd_ptr_nxt = '0;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = ERR_CSUM;
                        end
                    end else if (w_to_expired) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_TIMEOUT;
                    end
                end

                ST_DELIVER: begin
                    // The buffer is busy replaying; new bytes cannot be stored anywhere.
                    if (rx_valid && !rx_break) begin
                        w_ovr_inc = 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_last) begin
                            w_state_nxt = ST_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_rd_ptr_nxt = r_rd_ptr + LW'(1);
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_err) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_csum     <= 8'h00;
            r_to_cnt   <= '0;
            r_rx_en    <= 1'b0;
            r_frm_done <= 1'b0;
            r_frm_err  <= 1'b0;
            r_err_code <= ERR_NONE;
            r_overrun  <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_csum     <= w_csum_nxt;
            r_rx_en    <= enable;
            r_frm_done <= w_done;
            r_frm_err  <= w_err;
            // A byte arriving on the expiry cycle wins: the counter restarts instead of erroring.
            if (w_to_run && !rx_valid && !w_err) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_err) begin
                r_err_code <= w_err_code;
            end
            if (w_ovr_inc && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: drives UART byte strobes, scoreboards delivered payload.
// Expected bytes are queued as frames are sent and popped at each observed handshake.
module tb_uart_rx_frame_ctrl;

    localparam int ML = 16;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_break = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frm_ready = 1'b0;
    logic       rx_en;
    logic [7:0] frm_data;
    logic       frm_valid;
    logic       frm_last;
    logic       frm_done;
    logic       frm_err;
    logic [2:0] err_code;
    logic [7:0] overrun_cnt;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .MAX_LEN        (ML),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .rx_en       (rx_en),
        .rx_valid    (rx_valid),
        .rx_break    (rx_break),
        .rx_data     (rx_data),
        .frm_data    (frm_data),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_last    (frm_last),
        .frm_done    (frm_done),
        .frm_err     (frm_err),
        .err_code    (err_code),
        .overrun_cnt (overrun_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] tx_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         valid_cyc = 0;
    logic       prev_last = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pulse counting, handshake scoreboard, hold-while-stalled and done timing.
    always @(negedge clk) begin
        if (frm_done) done_cnt++;
        if (frm_err) err_cnt++;
        if (frm_valid) valid_cyc++;
        if (prev_last || frm_done) begin
            check("done_one_cycle_after_last", frm_done, prev_last);
            check("valid_low_at_done", frm_valid, 1'b0);
        end
        if (prev_stall) begin
            check("hold_valid", frm_valid, 1'b1);
            check("hold_data", frm_data, prev_data);
        end
        prev_last = 1'b0;
        if (frm_valid && frm_ready) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_xfer observed=0x%0h expected=no_transfer", frm_data);
            end
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("frm_data", frm_data, mon_e.d);
                check("frm_last", frm_last, mon_e.l);
                prev_last = mon_e.l;
            end
        end
        prev_stall = resetn && enable && frm_valid && !frm_ready;
        prev_data  = frm_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic brk, input int gap);
        rx_data  = b;
        rx_break = brk;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_break = 1'b0;
        repeat (gap) step();
    endtask

    // Sends SYNC, LEN, tx_q payload and the correct CSUM; queues the expected deliveries.
    task automatic send_good();
        logic [7:0] cs;
        cs = 8'(tx_q.size());
        send_byte(8'hA5, 1'b0, 2);
        send_byte(cs, 1'b0, 2);
        for (int i = 0; i < tx_q.size(); i++) begin
            sb_q.push_back({tx_q[i], (i == tx_q.size() - 1)});
            cs = cs ^ tx_q[i];
            send_byte(tx_q[i], 1'b0, 2);
        end
        send_byte(cs, 1'b0, 0);
        check("valid_cycle_after_csum", frm_valid, 1'b1);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) step();
        check("done_count", done_cnt, target);
    endtask

    task automatic wait_err(input int target, input int budget);
        for (int i = 0; i < budget && err_cnt < target; i++) step();
        check("err_count", err_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_en"}, rx_en, 1'b0);
        check({tag, "_frm_valid"}, frm_valid, 1'b0);
        check({tag, "_frm_last"}, frm_last, 1'b0);
        check({tag, "_frm_done"}, frm_done, 1'b0);
        check({tag, "_frm_err"}, frm_err, 1'b0);
        check({tag, "_frm_data"}, frm_data, 8'h00);
        check({tag, "_err_code"}, err_code, 3'd0);
        check({tag, "_overrun"}, overrun_cnt, 8'd0);
    endtask

    initial begin
        int e0;
        int d0;
        int v0;

        // Reset state, with enable already high so rx_en must still read low.
        resetn = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        resetn = 1'b1;
        step();
        check("rx_en_follows_enable", rx_en, 1'b1);

        // Basic 3-byte frame with the consumer always ready.
        frm_ready = 1'b1;
        tx_q = '{8'h11, 8'h22, 8'h33};
        send_good();
        wait_done(1, 20);
        check("sb_empty_a", sb_q.size(), 0);
        check("err_code_a", err_code, 3'd0);
        check("no_err_a", err_cnt, 0);
        check("overrun_a", overrun_cnt, 8'd0);

        // Same frame with a 5-cycle stall on byte 22 and a SYNC byte arriving mid-delivery.
        frm_ready = 1'b0;
        send_good();
        check("first_byte_presented", frm_data, 8'h11);
        frm_ready = 1'b1;
        step();
        frm_ready = 1'b0;
        send_byte(8'hA5, 1'b0, 4);
        check("stalled_data", frm_data, 8'h22);
        check("overrun_one", overrun_cnt, 8'd1);
        frm_ready = 1'b1;
        wait_done(2, 20);
        check("sb_empty_b", sb_q.size(), 0);
        check("no_err_b", err_cnt, 0);

        // Checksum error: 02^AA^BB = 13, so 00 is wrong.
        e0 = err_cnt;
        v0 = valid_cyc;
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h02, 1'b0, 2);
        send_byte(8'hAA, 1'b0, 2);
        send_byte(8'hBB, 1'b0, 2);
        send_byte(8'h00, 1'b0, 2);
        check("csum_err_pulse", err_cnt, e0 + 1);
        check("csum_err_code", err_code, 3'd2);
        check("csum_no_valid", valid_cyc, v0);

        // Length errors: zero and MAX_LEN+1.
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h00, 1'b0, 2);
        check("len0_err_pulse", err_cnt, e0 + 2);
        check("len0_err_code", err_code, 3'd1);
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h11, 1'b0, 2);
        check("len17_err_pulse", err_cnt, e0 + 3);
        check("len17_err_code", err_code, 3'd1);

        // Inter-byte timeout: nothing before ~TO cycles, then error 3.
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h04, 1'b0, 2);
        send_byte(8'h01, 1'b0, 0);
        repeat (90) step();
        check("no_early_timeout", err_cnt, e0 + 3);
        wait_err(e0 + 4, 30);
        check("timeout_err_code", err_code, 3'd3);

        // BREAK on the third byte after SYNC.
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h04, 1'b0, 2);
        send_byte(8'h01, 1'b0, 2);
        send_byte(8'h02, 1'b1, 2);
        check("break_err_pulse", err_cnt, e0 + 5);
        check("break_err_code", err_code, 3'd4);

        // BREAK ignored in IDLE and DELIVER; a MAX_LEN frame succeeds and leaves err_code alone.
        send_byte(8'hA5, 1'b1, 2);
        frm_ready = 1'b0;
        tx_q.delete();
        for (int i = 0; i < ML; i++) tx_q.push_back(8'(8'h40 + i));
        send_good();
        send_byte(8'hA5, 1'b1, 2);
        check("break_in_deliver_no_overrun", overrun_cnt, 8'd1);
        check("break_ignored_no_err", err_cnt, e0 + 5);
        check("maxlen_first_byte", frm_data, 8'h40);
        frm_ready = 1'b1;
        wait_done(3, 40);
        check("sb_empty_max", sb_q.size(), 0);
        check("err_code_kept", err_code, 3'd4);

        // Enable dropped mid-payload: silent abort.
        e0 = err_cnt;
        d0 = done_cnt;
        send_byte(8'hA5, 1'b0, 1);
        send_byte(8'h03, 1'b0, 1);
        send_byte(8'h11, 1'b0, 1);
        enable = 1'b0;
        step();
        step();
        check("disabled_valid", frm_valid, 1'b0);
        check("disabled_rx_en", rx_en, 1'b0);
        enable = 1'b1;
        step();

        // Reach DELIVER without consuming (02^5A^6B = 33), then reset mid-delivery.
        frm_ready = 1'b0;
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h02, 1'b0, 2);
        send_byte(8'h5A, 1'b0, 2);
        send_byte(8'h6B, 1'b0, 2);
        send_byte(8'h33, 1'b0, 0);
        check("deliver_before_reset", frm_valid, 1'b1);
        check("deliver_data_before_reset", frm_data, 8'h5A);
        resetn = 1'b0;
        step();
        check_reset_outputs("midreset");
        resetn = 1'b1;
        step();
        step();
        check("abort_no_err", err_cnt, e0);
        check("abort_no_done", done_cnt, d0);

        // Block is fully usable afterwards.
        frm_ready = 1'b1;
        tx_q = '{8'h7E};
        send_good();
        wait_done(d0 + 1, 20);
        check("sb_empty_final", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
